// File: rtl/digit_seq_pkg.sv
// Shared types and ROM contents for the digit sequencer.
package digit_seq_pkg;

  localparam int unsigned ROM_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Fixed digit pattern: entry i = (7*i + 3) mod 16
  function automatic logic [3:0] rom_digit(input int unsigned idx);
    return 4'((7 * idx + 3) % 16);
  endfunction

endpackage

// File: rtl/seq_step_edge.sv
// Rising-edge detector for the single-step request; history is a registered copy of step.
module seq_step_edge (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic rise_c
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign rise_c = step & ~step_q;

endmodule

// File: rtl/digit_sequencer.sv
// Timed digit stream for the seg7hex decoder with run/pause/step control.
// Optional blank gap between digits enabled by DIGIT_SEQUENCER_GAP_EN.
module digit_sequencer
  import digit_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = ROM_DEPTH,
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     pause,
  input  logic                     step,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [3:0]               hex,
  output logic                     blank,
  output logic [$clog2(DEPTH)-1:0] index,
  output logic                     wrap
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CNT_W = (DWELL_W > GAP_W) ? DWELL_W : GAP_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         hex_q, hex_d;
  logic               blank_q, blank_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               wrap_q, wrap_d;
  logic [IDX_W-1:0]   idx_nxt;
  logic               step_rise_c;
  logic               expire;
  logic               load_next;

  seq_step_edge u_step_edge (
    .clk    (clk),
    .reset  (reset),
    .step   (step),
    .rise_c (step_rise_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hex_q   <= 4'h0;
      blank_q <= 1'b1;
      index_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      index_q <= index_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state: run=0 dominates, then pause/step, then counter expiry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hex_d     = hex_q;
    blank_d   = blank_q;
    index_d   = index_q;
    wrap_d    = 1'b0;
    expire    = 1'b0;
    load_next = 1'b0;
    idx_nxt   = index_q + IDX_W'(1);

    if (!run) begin
      state_d = IDLE;
      blank_d = 1'b1;
      index_d = '0;
    end else begin
      if (state_q == SHOW || state_q == GAP) begin
        if (pause)                expire = step_rise_c;
        else if (cnt_q != '0)     cnt_d  = cnt_q - CNT_W'(1);
        else                      expire = 1'b1;
      end

      case (state_q)
        IDLE: begin
          state_d = SHOW;
          index_d = '0;
          hex_d   = rom_digit(0);
          blank_d = 1'b0;
          cnt_d   = CNT_W'(dwell);
        end
        SHOW: begin
          if (expire) begin
`ifdef DIGIT_SEQUENCER_GAP_EN
            state_d = GAP;
            blank_d = 1'b1;
            cnt_d   = CNT_W'(GAP_CYCLES - 1);
`else
            load_next = 1'b1;
`endif
          end
        end
        GAP: begin
          if (expire) load_next = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (load_next) begin
        state_d = SHOW;
        index_d = idx_nxt;
        hex_d   = rom_digit(32'(idx_nxt));
        blank_d = 1'b0;
        cnt_d   = CNT_W'(dwell);
        wrap_d  = (index_q == IDX_W'(DEPTH - 1));
      end
    end
  end

  assign hex   = hex_q;
  assign blank = blank_q;
  assign index = index_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed self-checking bench for digit_sequencer (table vectors plus corner sequences).
module tb_digit_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       pause;
  logic       step;
  logic [7:0] dwell;
  logic [3:0] hex;
  logic       blank;
  logic [4:0] index;
  logic       wrap;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       run;
    logic       pause;
    logic       step;
    logic [7:0] dwell;
    logic [3:0] hex;
    logic       blank;
    logic [4:0] idx;
    logic       wrap;
  } vec_t;

  localparam int NV = 37;
  vec_t tbl [NV];

  digit_sequencer #(.DEPTH(32), .DWELL_W(8), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .pause (pause),
    .step  (step),
    .dwell (dwell),
    .hex   (hex),
    .blank (blank),
    .index (index),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_digit(input int i);
    return 4'((7 * i + 3) % 16);
  endfunction

  function automatic vec_t mk(input logic r, input logic p, input logic s, input logic [7:0] d,
                              input logic [3:0] h, input logic b, input logic [4:0] ix,
                              input logic w);
    vec_t v;
    v.run = r; v.pause = p; v.step = s; v.dwell = d;
    v.hex = h; v.blank = b; v.idx = ix; v.wrap = w;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] eh, input logic eb,
                       input logic [4:0] ei, input logic ew);
    n_cmp++;
    if ({hex, blank, index, wrap} !== {eh, eb, ei, ew}) begin
      n_err++;
      $display("FAIL %s: got hex=%h blank=%b index=%0d wrap=%b, want hex=%h blank=%b index=%0d wrap=%b",
               name, hex, blank, index, wrap, eh, eb, ei, ew);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; pause = 1'b0; step = 1'b0; dwell = 8'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Basic run, run drop, pause/step, dwell change, dwell=0, idle step
    tbl[0]  = mk(1,0,0,8'd2, 4'h3,0,5'd0,0);
    tbl[1]  = mk(1,0,0,8'd2, 4'h3,0,5'd0,0);
    tbl[2]  = mk(1,0,0,8'd2, 4'h3,0,5'd0,0);
    tbl[3]  = mk(1,0,0,8'd2, 4'hA,0,5'd1,0);
    tbl[4]  = mk(1,0,0,8'd2, 4'hA,0,5'd1,0);
    tbl[5]  = mk(1,0,0,8'd2, 4'hA,0,5'd1,0);
    tbl[6]  = mk(1,0,0,8'd2, 4'h1,0,5'd2,0);
    tbl[7]  = mk(1,0,0,8'd2, 4'h1,0,5'd2,0);
    tbl[8]  = mk(1,0,0,8'd2, 4'h1,0,5'd2,0);
    tbl[9]  = mk(1,0,0,8'd2, 4'h8,0,5'd3,0);
    tbl[10] = mk(0,0,0,8'd2, 4'h8,1,5'd0,0);
    tbl[11] = mk(1,0,0,8'd5, 4'h3,0,5'd0,0);
    for (int i = 12; i <= 16; i++) tbl[i] = mk(1,0,0,8'd5, 4'h3,0,5'd0,0);
    tbl[17] = mk(1,0,0,8'd5, 4'hA,0,5'd1,0);
    tbl[18] = mk(1,0,0,8'd5, 4'hA,0,5'd1,0);
    tbl[19] = mk(1,1,0,8'd5, 4'hA,0,5'd1,0);
    tbl[20] = mk(1,1,0,8'd5, 4'hA,0,5'd1,0);
    tbl[21] = mk(1,1,1,8'd5, 4'h1,0,5'd2,0);
    tbl[22] = mk(1,1,1,8'd5, 4'h1,0,5'd2,0);
    tbl[23] = mk(1,1,1,8'd5, 4'h1,0,5'd2,0);
    tbl[24] = mk(1,1,1,8'd5, 4'h1,0,5'd2,0);
    tbl[25] = mk(1,1,0,8'd5, 4'h1,0,5'd2,0);
    tbl[26] = mk(1,0,0,8'd5, 4'h1,0,5'd2,0);
    for (int i = 27; i <= 30; i++) tbl[i] = mk(1,0,0,8'd0, 4'h1,0,5'd2,0);
    tbl[31] = mk(1,0,0,8'd0, 4'h8,0,5'd3,0);
    tbl[32] = mk(1,0,0,8'd0, 4'hF,0,5'd4,0);
    tbl[33] = mk(1,0,0,8'd0, 4'h6,0,5'd5,0);
    tbl[34] = mk(0,0,1,8'd0, 4'h6,1,5'd0,0);
    tbl[35] = mk(0,1,0,8'd0, 4'h6,1,5'd0,0);
    tbl[36] = mk(1,0,1,8'd0, 4'h3,0,5'd0,0);

    do_reset();
    check("reset_values", 4'h0, 1'b1, 5'd0, 1'b0);

`ifndef DIGIT_SEQUENCER_GAP_EN
    for (int i = 0; i < NV; i++) begin
      run = tbl[i].run; pause = tbl[i].pause; step = tbl[i].step; dwell = tbl[i].dwell;
      tick();
      check($sformatf("vec%0d", i), tbl[i].hex, tbl[i].blank, tbl[i].idx, tbl[i].wrap);
    end

    // Wrap: dwell=0 walks the whole ROM one digit per cycle
    do_reset();
    run = 1'b1; dwell = 8'd0;
    for (int k = 0; k < 32; k++) begin
      tick();
      check($sformatf("walk%0d", k), exp_digit(k), 1'b0, 5'(k), 1'b0);
    end
    check("last_is_C", 4'hC, 1'b0, 5'd31, 1'b0);
    tick();
    check("wrap_pulse", 4'h3, 1'b0, 5'd0, 1'b1);
    tick();
    check("wrap_clears", 4'hA, 1'b0, 5'd1, 1'b0);

    // Reset mid-operation while run stays high
    do_reset();
    run = 1'b1; dwell = 8'd0;
    for (int k = 0; k < 6; k++) tick();
    check("pre_reset_idx5", exp_digit(5), 1'b0, 5'd5, 1'b0);
    reset = 1'b1;
    tick();
    check("midop_reset", 4'h0, 1'b1, 5'd0, 1'b0);
    tick();
    check("reset_held", 4'h0, 1'b1, 5'd0, 1'b0);
    reset = 1'b0;
    tick();
    check("after_reset_show", 4'h3, 1'b0, 5'd0, 1'b0);
`else
    // Gap build: GAP_CYCLES=2, dwell=1
    run = 1'b1; dwell = 8'd1;
    begin
      logic [3:0] gh [12];
      logic       gb [12];
      logic [4:0] gi [12];
      for (int k = 0; k < 12; k++) begin
        gh[k] = exp_digit(k / 4);
        gb[k] = ((k % 4) >= 2);
        gi[k] = 5'(k / 4);
      end
      for (int k = 0; k < 12; k++) begin
        tick();
        check($sformatf("gap%0d", k), gh[k], gb[k], gi[k], 1'b0);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/digit_sequencer.md
Name: digit_sequencer

Overview:
- Upstream feeder for the seg7hex decoder.
- Steps through a fixed 32-entry digit ROM and presents each 4-bit digit for a programmable dwell time.
- Supports run/pause/single-step control, a blank flag, and a wrap pulse.
- Replaces free-running per-clock digit generation with a timed, controllable stream. The top-level drives seg7hex from hex and gates the segments with blank.

Parameters:
- DEPTH, 32, number of ROM entries; must be a power of 2; IDX_W = log2(DEPTH).
- DWELL_W, 8, width of the dwell input.
- GAP_CYCLES, 1, blank cycles between digits; range 1..15; used only when the gap feature is enabled.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level; 1 = sequence active, 0 = idle.
- pause  input  1  level; freezes the dwell/gap counter and the state.
- step  input  1  single-step request; rising-edge detected internally.
- dwell  input  DWELL_W  a digit is shown for dwell+1 cycles; sampled on each digit load.
- hex  output  4  current digit, registered.
- blank  output  1  1 = display off; registered.
- index  output  IDX_W  ROM address of the current digit.
- wrap  output  1  one-cycle pulse when index loads 0 from DEPTH-1.

Behaviour:
- ROM contents: entry i = (7*i + 3) mod 16. Sequence starts 3, A, 1, 8; entry 31 = C.
- Reset values: state IDLE, hex=0, blank=1, index=0, wrap=0, counter=0, step history=0.
- Priority, highest first: reset > run=0 > pause/step > counter expiry.
- IDLE:
  - blank=1, index=0.
  - When run=1 is sampled, next state is SHOW with index=0, hex=ROM[0], blank=0, cnt=dwell.
  - First digit is visible one cycle after run is first sampled high.
- SHOW:
  - If cnt≠0: cnt decrements.
  - If cnt==0: advance.
    - Gap feature enabled: go to GAP with blank=1, hex unchanged, cnt=GAP_CYCLES-1.
    - Gap feature disabled: load the next digit immediately.
- Load-next:
  - index = (index+1) mod DEPTH; hex=ROM[index]; blank=0; cnt=dwell (freshly sampled).
  - wrap=1 for exactly that cycle if the old index was DEPTH-1.
- GAP: counts down; at cnt==0 performs load-next.
- pause=1 in SHOW or GAP:
  - Counter and outputs hold, including at cnt==0.
  - A step rising edge performs the expiry action that cycle: SHOW goes to GAP or load-next; GAP goes to load-next.
- Step:
  - step=1 held across several cycles is a single event.
  - Step edges are ignored when pause=0 and in IDLE, but the step history register still updates.
- run=0 in any state: next cycle is IDLE with blank=1 and index=0; hex holds its last value; wrap=0.
- dwell change mid-digit has no effect until the next load.
- dwell=0: each digit is shown for one cycle (back-to-back with gap disabled).
- Outputs change only on clock edges; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: DIGIT_SEQUENCER_GAP_EN.
- Defined: the GAP state exists; GAP_CYCLES blank cycles separate consecutive digits, including across wrap.
- Undefined: no GAP state; SHOW expiry loads the next digit directly; GAP_CYCLES is unused.

Decomposition:
- Package digit_seq_pkg holds:
  - state enum (IDLE, SHOW, GAP);
  - ROM_DEPTH constant;
  - function rom_digit(idx) returning (7*idx+3) mod 16.
- One sub-module, seq_step_edge: registered rising-edge detector for step, with synchronous reset.
- The counter/FSM stays in the top module.

Test Plan:
- Basic run, gap disabled: dwell=2, run=1 → hex sequence 3,3,3,A,A,A,1,1,1,8…; blank=0 throughout; index 0,1,2,3.
- Wrap: dwell=0, gap disabled, run 33 cycles → index 31 shows C, next cycle index=0 shows 3 with wrap=1 for exactly one cycle.
- Pause and step: dwell=5, pause at mid-digit 1 → hex holds A indefinitely. A step pulse held for 4 cycles → exactly one advance to 1. Release pause → digit 1 runs its full 6 cycles.
- Run drop: run=0 during digit 2 → next cycle blank=1, index=0. run=1 again → shows 3 after one cycle.
- Mid-operation reset: reset pulse during SHOW with index=5 → next cycle all outputs at reset values; state IDLE even with run=1 held until after reset falls.
- Gap enabled: GAP_CYCLES=2, dwell=1 → blank pattern 0,0,1,1,0,0,1,1; hex 3,3,3,3,A,A,A,A.
